irq_dispatch_ctrl: RTL and testbench

- Sequences SM83 interrupt dispatch against the CPU register file and the memory bus.
- At an instruction boundary with interrupts enabled and a pending source, it does four things in order:
  - stalls the core;
  - clears IME;
  - pushes PC onto the stack through a request/acknowledge write port, decrementing SP via the register file's SP write port;
  - loads PC with the highest-priority vector and clears that IF bit.
- Sits beside the core's main sequencer and shares the register file's PC/SP write ports, which the core yields while `busy` is high.

---
 rtl/irq_dispatch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_irq_dispatch_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch_ctrl.sv
// irq_dispatch_ctrl: SM83 interrupt dispatch sequencer (stall core, clear IME, push PC, jump to vector).
// Optional IRQ_DISPATCH_CANCEL_EN: re-select the serviced source at the jump (IE-overwrite quirk).
module irq_dispatch_ctrl #(
   parameter logic [15:0] VEC_BASE = 16'h0040,
   parameter int unsigned NUM_SRC  = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               boundary,
   input  logic               halted,
   input  logic               ime,
   input  logic [7:0]         r_ie,
   input  logic [NUM_SRC-1:0] if_flags,
   input  logic [15:0]        r_pc,
   input  logic [15:0]        r_sp,
   output logic               busy,
   output logic               ime_clr,
   output logic               wake,
   output logic [NUM_SRC-1:0] if_clr,
   output logic               pc_wen,
   output logic [15:0]        w_pc,
   output logic               sp_wen,
   output logic [15:0]        w_sp,
   output logic               mem_req,
   output logic [15:0]        mem_addr,
   output logic [7:0]         mem_wdata,
   input  logic               mem_ack
);

   localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT0, S_WAIT1, S_PUSH_HI, S_PUSH_LO, S_JUMP
   } state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   src_q;
   logic               wake_cond_q;
   logic               busy_q, ime_clr_q, wake_q, pc_wen_q, sp_wen_q, mem_req_q;
   logic [NUM_SRC-1:0] if_clr_q;
   logic [15:0]        w_pc_q, w_sp_q, mem_addr_q;
   logic [7:0]         mem_wdata_q;

   logic [NUM_SRC-1:0] pend;
   logic               pend_any;
   logic               wake_cond;
   logic [IDX_W-1:0]   sel_idx;
   logic [15:0]        jump_pc;
   logic [NUM_SRC-1:0] jump_clr;

   // Lowest set bit has the highest priority.
   function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
      lowest_idx = '0;
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--)
         if (v[i]) lowest_idx = IDX_W'(i);
   endfunction

   function automatic logic [15:0] vec_of(input logic [IDX_W-1:0] idx);
      vec_of = VEC_BASE + 16'({idx, 3'b000});
   endfunction

   function automatic logic [NUM_SRC-1:0] onehot_of(input logic [IDX_W-1:0] idx);
      onehot_of = NUM_SRC'(1) << idx;
   endfunction

   assign pend      = r_ie[NUM_SRC-1:0] & if_flags;
   assign pend_any  = |pend;
   assign wake_cond = halted & pend_any;
   assign sel_idx   = lowest_idx(pend);

`ifdef IRQ_DISPATCH_CANCEL_EN
   // The high-byte push may have rewritten IE, so the winner is decided again at the jump.
   assign jump_pc  = pend_any ? vec_of(sel_idx) : 16'h0000;
   assign jump_clr = pend_any ? onehot_of(sel_idx) : '0;
`else
   assign jump_pc  = vec_of(src_q);
   assign jump_clr = onehot_of(src_q);
`endif

   generate
      if (NUM_SRC < 8) begin : g_ie_hi
         logic unused_ie_hi;
         assign unused_ie_hi = ^r_ie[7:NUM_SRC];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         wake_cond_q <= 1'b0;
         busy_q      <= 1'b0;
         ime_clr_q   <= 1'b0;
         wake_q      <= 1'b0;
         pc_wen_q    <= 1'b0;
         sp_wen_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         if_clr_q    <= '0;
         w_pc_q      <= '0;
         w_sp_q      <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         ime_clr_q   <= 1'b0;
         pc_wen_q    <= 1'b0;
         sp_wen_q    <= 1'b0;
         if_clr_q    <= '0;
         wake_cond_q <= wake_cond;
         wake_q      <= wake_cond & ~wake_cond_q;
         case (state_q)
            S_IDLE: begin
               if ((boundary | halted) & ime & pend_any) begin
                  state_q   <= S_WAIT0;
                  busy_q    <= 1'b1;
                  ime_clr_q <= 1'b1;
                  src_q     <= sel_idx;
               end
            end
            S_WAIT0: state_q <= S_WAIT1;
            S_WAIT1: begin
               state_q     <= S_PUSH_HI;
               mem_req_q   <= 1'b1;
               mem_addr_q  <= r_sp - 16'd1;
               mem_wdata_q <= r_pc[15:8];
            end
            // Each pushed address is the new SP, so w_sp reuses it rather than waiting on r_sp.
            S_PUSH_HI: begin
               if (mem_ack) begin
                  state_q     <= S_PUSH_LO;
                  sp_wen_q    <= 1'b1;
                  w_sp_q      <= mem_addr_q;
                  mem_addr_q  <= mem_addr_q - 16'd1;
                  mem_wdata_q <= r_pc[7:0];
               end
            end
            S_PUSH_LO: begin
               if (mem_ack) begin
                  state_q     <= S_JUMP;
                  sp_wen_q    <= 1'b1;
                  w_sp_q      <= mem_addr_q;
                  mem_req_q   <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  pc_wen_q    <= 1'b1;
                  w_pc_q      <= jump_pc;
                  if_clr_q    <= jump_clr;
               end
            end
            S_JUMP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               w_pc_q  <= '0;
               w_sp_q  <= '0;
            end
            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               mem_req_q   <= 1'b0;
               mem_addr_q  <= '0;
               mem_wdata_q <= '0;
               w_pc_q      <= '0;
               w_sp_q      <= '0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign ime_clr   = ime_clr_q;
   assign wake      = wake_q;
   assign if_clr    = if_clr_q;
   assign pc_wen    = pc_wen_q;
   assign w_pc      = w_pc_q;
   assign sp_wen    = sp_wen_q;
   assign w_sp      = w_sp_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Directed bench for irq_dispatch_ctrl with a small register-file and bus model in the stimulus loop.
// Expectations follow IRQ_DISPATCH_CANCEL_EN when the bench is built with it.
module tb_irq_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        boundary, halted, ime;
   logic [7:0]  r_ie;
   logic [4:0]  if_flags;
   logic [15:0] r_pc, r_sp;
   logic        busy, ime_clr, wake, pc_wen, sp_wen, mem_req, mem_ack;
   logic [4:0]  if_clr;
   logic [15:0] w_pc, w_sp, mem_addr;
   logic [7:0]  mem_wdata;

   int          n_vec = 0;
   int          n_err = 0;

   int          n_busy, n_wake, n_wr, n_pcwen, wait_cnt, ack_delay;
   logic [15:0] wr_addr [4];
   logic [7:0]  wr_data [4];
   logic [4:0]  if_seen;
   logic        unstable;
   logic [15:0] hold_addr;
   logic [7:0]  hold_data;

   irq_dispatch_ctrl #(.VEC_BASE(16'h0040), .NUM_SRC(5)) dut (
      .clk(clk), .rst(rst), .boundary(boundary), .halted(halted), .ime(ime),
      .r_ie(r_ie), .if_flags(if_flags), .r_pc(r_pc), .r_sp(r_sp),
      .busy(busy), .ime_clr(ime_clr), .wake(wake), .if_clr(if_clr),
      .pc_wen(pc_wen), .w_pc(w_pc), .sp_wen(sp_wen), .w_sp(w_sp),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic clear_stats();
      n_busy = 0; n_wake = 0; n_wr = 0; n_pcwen = 0; wait_cnt = 0;
      if_seen = '0; unstable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wr_addr[i] = '0;
         wr_data[i] = '0;
      end
   endtask

   // One clock: sample outputs at negedge, answer the bus, then apply register-file writes.
   task automatic tick();
      logic        s_ack, s_req, s_pcwen, s_spwen, s_imeclr;
      logic [15:0] s_wpc, s_wsp, s_addr;
      logic [7:0]  s_data;
      logic [4:0]  s_ifclr;
      @(negedge clk);
      if (busy) n_busy++;
      if (wake) n_wake++;
      s_req = mem_req;
      if (mem_req) begin
         if (wait_cnt > 0 && (mem_addr !== hold_addr || mem_wdata !== hold_data)) unstable = 1'b1;
         hold_addr = mem_addr;
         hold_data = mem_wdata;
         mem_ack   = (wait_cnt == ack_delay);
      end else begin
         mem_ack = 1'b0;
      end
      s_ack = mem_ack; s_addr = mem_addr; s_data = mem_wdata;
      s_pcwen = pc_wen; s_wpc = w_pc; s_spwen = sp_wen; s_wsp = w_sp;
      s_ifclr = if_clr; s_imeclr = ime_clr;
      @(posedge clk);
      #1;
      mem_ack  = 1'b0;
      boundary = 1'b0;
      if (s_req && s_ack) begin
         if (n_wr < 4) begin
            wr_addr[n_wr] = s_addr;
            wr_data[n_wr] = s_data;
         end
         n_wr++;
         if (s_addr == 16'hFFFF) r_ie = s_data;
         wait_cnt = 0;
      end else if (s_req) begin
         wait_cnt++;
      end
      if (s_pcwen) begin
         r_pc = s_wpc;
         n_pcwen++;
      end
      if (s_spwen) r_sp = s_wsp;
      if (s_imeclr) ime = 1'b0;
      if_flags = if_flags & ~s_ifclr;
      if_seen  = if_seen | s_ifclr;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic setup(input logic [15:0] pc, input logic [15:0] sp, input logic [7:0] ie,
                        input logic [4:0] iflg, input int dly);
      r_pc = pc; r_sp = sp; r_ie = ie; if_flags = iflg; ime = 1'b1; ack_delay = dly;
      clear_stats();
   endtask

   task automatic test_reset();
      rst = 1'b1; boundary = 1'b0; halted = 1'b0; ime = 1'b0; mem_ack = 1'b0;
      r_ie = '0; if_flags = '0; r_pc = '0; r_sp = '0; ack_delay = 0;
      clear_stats();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy, ime_clr, wake, if_clr, pc_wen, w_pc, sp_wen, w_sp, mem_req, mem_addr, mem_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got busy=%b req=%b addr=%h pc_wen=%b, required all 0", busy, mem_req, mem_addr, pc_wen);
      end
      rst = 1'b0;
      run(2);
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle_busy: got %b, required 0", busy);
      end
   endtask

   task automatic test_basic();
      setup(16'h1234, 16'hFFFE, 8'h01, 5'b00001, 0);
      boundary = 1'b1;
      run(10);
      n_vec++;
      if (wr_addr[0] !== 16'hFFFD || wr_data[0] !== 8'h12) begin
         n_err++;
         $display("FAIL basic_push_hi: got %h@%h, required 12@fffd", wr_data[0], wr_addr[0]);
      end
      n_vec++;
      if (wr_addr[1] !== 16'hFFFC || wr_data[1] !== 8'h34) begin
         n_err++;
         $display("FAIL basic_push_lo: got %h@%h, required 34@fffc", wr_data[1], wr_addr[1]);
      end
      n_vec++;
      if (r_sp !== 16'hFFFC) begin
         n_err++;
         $display("FAIL basic_sp: got %h, required fffc", r_sp);
      end
      n_vec++;
      if (r_pc !== 16'h0040) begin
         n_err++;
         $display("FAIL basic_pc: got %h, required 0040", r_pc);
      end
      n_vec++;
      if (if_seen !== 5'b00001) begin
         n_err++;
         $display("FAIL basic_if_clr: got %b, required 00001", if_seen);
      end
      n_vec++;
      if (n_busy !== 5) begin
         n_err++;
         $display("FAIL basic_busy_cycles: got %0d, required 5", n_busy);
      end
      n_vec++;
      if (ime !== 1'b0 || n_pcwen !== 1) begin
         n_err++;
         $display("FAIL basic_ime_pcwen: got ime=%b pc_wen_count=%0d, required ime=0 count=1", ime, n_pcwen);
      end
   endtask

   task automatic test_priority();
      setup(16'h2000, 16'hD000, 8'h1F, 5'b10100, 0);
      boundary = 1'b1;
      run(10);
      n_vec++;
      if (r_pc !== 16'h0050) begin
         n_err++;
         $display("FAIL prio_pc: got %h, required 0050", r_pc);
      end
      n_vec++;
      if (if_seen !== 5'b00100) begin
         n_err++;
         $display("FAIL prio_if_clr: got %b, required 00100", if_seen);
      end
   endtask

   task automatic test_wait_wrap();
      setup(16'hBEEF, 16'h0001, 8'h01, 5'b00001, 3);
      boundary = 1'b1;
      run(18);
      n_vec++;
      if (wr_addr[0] !== 16'h0000 || wr_data[0] !== 8'hBE) begin
         n_err++;
         $display("FAIL wrap_push_hi: got %h@%h, required be@0000", wr_data[0], wr_addr[0]);
      end
      n_vec++;
      if (wr_addr[1] !== 16'hFFFF || wr_data[1] !== 8'hEF) begin
         n_err++;
         $display("FAIL wrap_push_lo: got %h@%h, required ef@ffff", wr_data[1], wr_addr[1]);
      end
      n_vec++;
      if (r_sp !== 16'hFFFF) begin
         n_err++;
         $display("FAIL wrap_sp: got %h, required ffff", r_sp);
      end
      n_vec++;
      if (n_busy !== 11) begin
         n_err++;
         $display("FAIL wait_busy_cycles: got %0d, required 11", n_busy);
      end
      n_vec++;
      if (unstable !== 1'b0) begin
         n_err++;
         $display("FAIL wait_addr_data_stable: got changed=%b, required 0", unstable);
      end
      n_vec++;
      if (r_pc !== 16'h0040) begin
         n_err++;
         $display("FAIL wait_pc: got %h, required 0040", r_pc);
      end
   endtask

   task automatic test_halt_wake();
      setup(16'h3000, 16'hC000, 8'h04, 5'b00000, 0);
      ime = 1'b0; halted = 1'b1;
      run(2);
      if_flags = 5'b00100;
      run(8);
      n_vec++;
      if (n_wake !== 1) begin
         n_err++;
         $display("FAIL halt_wake_count_ime0: got %0d, required 1", n_wake);
      end
      n_vec++;
      if (n_busy !== 0 || n_wr !== 0) begin
         n_err++;
         $display("FAIL halt_no_dispatch: got busy_cycles=%0d writes=%0d, required 0 0", n_busy, n_wr);
      end
      halted = 1'b0; if_flags = '0;
      run(2);
      setup(16'h3000, 16'hC000, 8'h04, 5'b00000, 0);
      halted = 1'b1;
      run(2);
      if_flags = 5'b00100;
      run(10);
      n_vec++;
      if (n_wake !== 1) begin
         n_err++;
         $display("FAIL halt_wake_count_ime1: got %0d, required 1", n_wake);
      end
      n_vec++;
      if (r_pc !== 16'h0050 || n_busy !== 5) begin
         n_err++;
         $display("FAIL halt_dispatch: got pc=%h busy_cycles=%0d, required 0050 5", r_pc, n_busy);
      end
      halted = 1'b0;
      run(2);
   endtask

   task automatic test_cancel();
      setup(16'h0000, 16'h0000, 8'h01, 5'b00001, 0);
      boundary = 1'b1;
      run(10);
      n_vec++;
      if (wr_addr[0] !== 16'hFFFF || r_ie !== 8'h00) begin
         n_err++;
         $display("FAIL cancel_ie_overwrite: got addr=%h ie=%h, required ffff 00", wr_addr[0], r_ie);
      end
`ifdef IRQ_DISPATCH_CANCEL_EN
      n_vec++;
      if (r_pc !== 16'h0000 || n_pcwen !== 1) begin
         n_err++;
         $display("FAIL cancel_pc: got pc=%h pc_wen_count=%0d, required 0000 1", r_pc, n_pcwen);
      end
      n_vec++;
      if (if_seen !== 5'b00000) begin
         n_err++;
         $display("FAIL cancel_if_clr: got %b, required 00000", if_seen);
      end
`else
      n_vec++;
      if (r_pc !== 16'h0040 || n_pcwen !== 1) begin
         n_err++;
         $display("FAIL nocancel_pc: got pc=%h pc_wen_count=%0d, required 0040 1", r_pc, n_pcwen);
      end
      n_vec++;
      if (if_seen !== 5'b00001) begin
         n_err++;
         $display("FAIL nocancel_if_clr: got %b, required 00001", if_seen);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int guard;
      setup(16'h1234, 16'hFFFE, 8'h01, 5'b00001, 3);
      boundary = 1'b1;
      guard = 0;
      while (!(n_wr == 1 && mem_req === 1'b1) && guard < 20) begin
         tick();
         guard++;
      end
      n_vec++;
      if (guard >= 20) begin
         n_err++;
         $display("FAIL reset_mid_reach_push_lo: got writes=%0d req=%b after %0d cycles, required 1 1", n_wr, mem_req, guard);
      end
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if ({busy, mem_req, ime_clr, wake, if_clr, pc_wen, sp_wen, mem_addr, mem_wdata, w_pc, w_sp} !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got busy=%b req=%b addr=%h data=%h, required all 0", busy, mem_req, mem_addr, mem_wdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      setup(16'h4321, 16'hE000, 8'h01, 5'b00001, 0);
      boundary = 1'b1;
      run(10);
      n_vec++;
      if (r_pc !== 16'h0040 || n_busy !== 5) begin
         n_err++;
         $display("FAIL reset_mid_fresh: got pc=%h busy_cycles=%0d, required 0040 5", r_pc, n_busy);
      end
      n_vec++;
      if (wr_addr[1] !== 16'hDFFE || wr_data[1] !== 8'h21 || r_sp !== 16'hDFFE) begin
         n_err++;
         $display("FAIL reset_mid_fresh_push: got %h@%h sp=%h, required 21@dffe dffe", wr_data[1], wr_addr[1], r_sp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_priority();
      test_wait_wrap();
      test_halt_wake();
      test_cancel();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
